// File: rtl/ahb_bridge_pkg.sv
// Shared constants for the AHB bridge: HTRANS encodings, data-phase select
// encodings, address regions and the one-hot decoder bit positions.
package ahb_bridge_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Data-phase select register encodings
  localparam logic [2:0] SEL_NONE    = 3'd0;
  localparam logic [2:0] SEL_S1      = 3'd1;
  localparam logic [2:0] SEL_S2      = 3'd2;
  localparam logic [2:0] SEL_S3      = 3'd3;
  localparam logic [2:0] SEL_S4      = 3'd4;
  localparam logic [2:0] SEL_DEFAULT = 3'd5;

  // Address regions, compared against haddr[31:28]
  localparam logic [3:0] REGION_S1 = 4'h0;
  localparam logic [3:0] REGION_S2 = 4'h1;
  localparam logic [3:0] REGION_S3 = 4'h2;
  localparam logic [3:0] REGION_S4 = 4'h3;

  // Bit positions in the decoder's one-hot output
  localparam int OH_S1      = 0;
  localparam int OH_S2      = 1;
  localparam int OH_S3      = 2;
  localparam int OH_S4      = 3;
  localparam int OH_DEFAULT = 4;
  localparam int OH_W       = 5;

  // True for transfer types that carry an address phase to a slave
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_bridge_decoder.sv
// Address decoder for the AHB bridge. Maps haddr[31:28] to one of the
// slaves or the internal default slave; output is all-zero when the
// master is not presenting an active (NONSEQ/SEQ) transfer.
// Optional feature macro: AHB_BRIDGE_S4_EN (enables region 0x3 -> slave 4).
module ahb_bridge_decoder
  import ahb_bridge_pkg::*;
(
  input  logic [3:0]      haddr_region,
  input  logic [1:0]      htrans,
  output logic [OH_W-1:0] sel_onehot
);

  // Region decode, qualified by an active transfer type
  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    sel_onehot = '0;
    if (htrans_active(htrans)) begin
      case (haddr_region)
        REGION_S1: sel_onehot[OH_S1] = 1'b1;
        REGION_S2: sel_onehot[OH_S2] = 1'b1;
        REGION_S3: sel_onehot[OH_S3] = 1'b1;
`ifdef AHB_BRIDGE_S4_EN
        REGION_S4: sel_onehot[OH_S4] = 1'b1;
`endif
        default:   sel_onehot[OH_DEFAULT] = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ahb_bridge.sv
// AHB single-master to four-slave bridge. The address phase is decoded
// combinationally into hsel_sN; a 3-bit data-phase select register
// remembers which slave owns the current data phase and steers its
// hrdata/hready back to the master. Unmapped regions go to an internal
// default slave that answers immediately with zero data.
// Optional feature macro: AHB_BRIDGE_S4_EN (slave 4 at region 0x3).
module ahb_bridge
  import ahb_bridge_pkg::*;
(
  input  logic        hclk,
  input  logic        hreset_n,   // asserted high despite the name
  // master side
  input  logic [31:0] haddr_m,
  input  logic [2:0]  hsize_m,
  input  logic [31:0] hwdata_m,
  input  logic        hwrite_m,
  input  logic [1:0]  htrans_m,
  output logic [31:0] hrdata_m,
  output logic        hready_m,
  // shared slave-side copies
  output logic [31:0] haddr_s,
  output logic [2:0]  hsize_s,
  output logic [31:0] hwdata_s,
  output logic        hwrite_s,
  // slave 1
  input  logic [31:0] hrdata_s1,
  input  logic        hready_s1,
  output logic        hsel_s1,
  // slave 2
  input  logic [31:0] hrdata_s2,
  input  logic        hready_s2,
  output logic        hsel_s2,
  // slave 3
  input  logic [31:0] hrdata_s3,
  input  logic        hready_s3,
  output logic        hsel_s3,
  // slave 4
  input  logic [31:0] hrdata_s4,
  input  logic        hready_s4,
  output logic        hsel_s4
);

  logic [OH_W-1:0] sel_onehot;
  logic [2:0]      target;
  logic [2:0]      sel_d;
  logic [2:0]      sel_q;

  // Zero-latency pass-through of the shared slave-side signals
  assign haddr_s  = haddr_m;
  assign hsize_s  = hsize_m;
  assign hwdata_s = hwdata_m;
  assign hwrite_s = hwrite_m;

  ahb_bridge_decoder u_decoder (
    .haddr_region (haddr_m[31:28]),
    .htrans       (htrans_m),
    .sel_onehot   (sel_onehot)
  );

  // Address-phase selects, forced low while reset is asserted
  always_comb begin
    hsel_s1 = sel_onehot[OH_S1] & ~hreset_n;
    hsel_s2 = sel_onehot[OH_S2] & ~hreset_n;
    hsel_s3 = sel_onehot[OH_S3] & ~hreset_n;
`ifdef AHB_BRIDGE_S4_EN
    hsel_s4 = sel_onehot[OH_S4] & ~hreset_n;
`else
    hsel_s4 = 1'b0;
`endif
  end

  // Encode the one-hot decode into the select-register encoding
  always_comb begin
    target = SEL_NONE;
    if      (sel_onehot[OH_S1])      target = SEL_S1;
    else if (sel_onehot[OH_S2])      target = SEL_S2;
    else if (sel_onehot[OH_S3])      target = SEL_S3;
    else if (sel_onehot[OH_S4])      target = SEL_S4;
    else if (sel_onehot[OH_DEFAULT]) target = SEL_DEFAULT;
  end

  // Next data-phase owner: load on a completing cycle, hold during wait states
  always_comb begin
    sel_d = sel_q;
    if (hready_m) sel_d = target;
  end

  // Data-phase select register
  always_ff @(posedge hclk or posedge hreset_n) begin
    // NOTE: non-blocking assignment for flop state so all flops sample the pre-edge values.
    if (hreset_n) sel_q <= SEL_NONE;
    else          sel_q <= sel_d;
  end

  // Response mux back to the master; NONE and DEFAULT answer ready with zero data.
  // Without slave 4 enabled the decoder never produces SEL_S4, so its inputs are unreachable.
  always_comb begin
    hrdata_m = 32'h0;
    hready_m = 1'b1;
    case (sel_q)
      SEL_S1: begin hrdata_m = hrdata_s1; hready_m = hready_s1; end
      SEL_S2: begin hrdata_m = hrdata_s2; hready_m = hready_s2; end
      SEL_S3: begin hrdata_m = hrdata_s3; hready_m = hready_s3; end
      SEL_S4: begin hrdata_m = hrdata_s4; hready_m = hready_s4; end
      default: begin hrdata_m = 32'h0; hready_m = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_ahb_bridge.sv
// Directed self-checking bench for ahb_bridge. Inputs change 1ns after the
// rising edge; outputs are sampled a further 1ns later, well clear of the edge.
// The slave-4 wait-state scenario runs when AHB_BRIDGE_S4_EN is defined;
// otherwise region 0x3 is checked as the default slave.
module tb_ahb_bridge;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic [31:0] haddr_m;
  logic [2:0]  hsize_m;
  logic [31:0] hwdata_m;
  logic        hwrite_m;
  logic [1:0]  htrans_m;
  logic [31:0] hrdata_m;
  logic        hready_m;
  logic [31:0] haddr_s;
  logic [2:0]  hsize_s;
  logic [31:0] hwdata_s;
  logic        hwrite_s;
  logic [31:0] hrdata_s1, hrdata_s2, hrdata_s3, hrdata_s4;
  logic        hready_s1, hready_s2, hready_s3, hready_s4;
  logic        hsel_s1, hsel_s2, hsel_s3, hsel_s4;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  always #5 hclk = ~hclk;

  ahb_bridge dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .haddr_m   (haddr_m),
    .hsize_m   (hsize_m),
    .hwdata_m  (hwdata_m),
    .hwrite_m  (hwrite_m),
    .htrans_m  (htrans_m),
    .hrdata_m  (hrdata_m),
    .hready_m  (hready_m),
    .haddr_s   (haddr_s),
    .hsize_s   (hsize_s),
    .hwdata_s  (hwdata_s),
    .hwrite_s  (hwrite_s),
    .hrdata_s1 (hrdata_s1),
    .hready_s1 (hready_s1),
    .hsel_s1   (hsel_s1),
    .hrdata_s2 (hrdata_s2),
    .hready_s2 (hready_s2),
    .hsel_s2   (hsel_s2),
    .hrdata_s3 (hrdata_s3),
    .hready_s3 (hready_s3),
    .hsel_s3   (hsel_s3),
    .hrdata_s4 (hrdata_s4),
    .hready_s4 (hready_s4),
    .hsel_s4   (hsel_s4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge (input-drive point)
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Let combinational paths settle before sampling
  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] hsel_vec();
    return {28'h0, hsel_s4, hsel_s3, hsel_s2, hsel_s1};
  endfunction

  initial begin
    // Reset held with an active transfer to slave 1 and a stalling slave 1
    hreset_n  = 1'b1;
    haddr_m   = 32'h0000_0000;
    hsize_m   = 3'b010;
    hwdata_m  = 32'h0;
    hwrite_m  = 1'b0;
    htrans_m  = NONSEQ;
    hrdata_s1 = 32'hdead_0001; hready_s1 = 1'b0;
    hrdata_s2 = 32'hdead_0002; hready_s2 = 1'b0;
    hrdata_s3 = 32'hdead_0003; hready_s3 = 1'b0;
    hrdata_s4 = 32'hdead_0004; hready_s4 = 1'b0;
    repeat (10) step();
    settle();
    check("reset_hsel",   hsel_vec(), 32'h0);
    check("reset_hready", {31'h0, hready_m}, 32'h1);
    check("reset_hrdata", hrdata_m, 32'h0);

    // Write to 0x0000_0000: address phase
    hreset_n  = 1'b0;
    htrans_m  = NONSEQ;
    haddr_m   = 32'h0000_0000;
    hwrite_m  = 1'b1;
    hsize_m   = 3'b010;
    hready_s1 = 1'b1;
    settle();
    check("wr_addr_hsel",   hsel_vec(), 32'h1);
    check("wr_addr_haddrs", haddr_s, 32'h0000_0000);
    check("wr_addr_hwrite", {31'h0, hwrite_s}, 32'h1);
    check("wr_addr_hsize",  {29'h0, hsize_s}, 32'h2);
    // Write data phase: hready_m follows hready_s1
    step();
    htrans_m  = IDLE;
    hwdata_m  = 32'h0000_1111;
    hready_s1 = 1'b0;
    settle();
    check("wr_data_hwdata", hwdata_s, 32'h0000_1111);
    check("wr_data_hsel",   hsel_vec(), 32'h0);
    check("wr_data_rdy_lo", {31'h0, hready_m}, 32'h0);
    hready_s1 = 1'b1;
    settle();
    check("wr_data_rdy_hi", {31'h0, hready_m}, 32'h1);
    // Idle after completion: select register back to NONE
    step();
    hready_s1 = 1'b0;
    settle();
    check("idle_hready", {31'h0, hready_m}, 32'h1);
    check("idle_hrdata", hrdata_m, 32'h0);

    // Pipelined reads: 0x0000_0004 then 0x2000_0000
    hwrite_m  = 1'b0;
    htrans_m  = NONSEQ;
    haddr_m   = 32'h0000_0004;
    hrdata_s1 = 32'h0000_2222; hready_s1 = 1'b1;
    hrdata_s3 = 32'h0f0f_0f0f; hready_s3 = 1'b1;
    settle();
    check("rd1_addr_hsel", hsel_vec(), 32'h1);
    step();
    htrans_m = SEQ;
    haddr_m  = 32'h2000_0000;
    settle();
    check("rd2_addr_hsel", hsel_vec(), 32'h4);
    check("rd1_data",      hrdata_m, 32'h0000_2222);
    step();
    htrans_m = IDLE;
    settle();
    check("rd2_data",      hrdata_m, 32'h0f0f_0f0f);
    check("rd2_hready",    {31'h0, hready_m}, 32'h1);
    step();

`ifdef AHB_BRIDGE_S4_EN
    // Wait state on slave 4; master holds next address (slave 1) meanwhile
    htrans_m  = NONSEQ;
    haddr_m   = 32'h3000_0000;
    hrdata_s4 = 32'hf0f0_f0f0;
    hready_s4 = 1'b0;
    settle();
    check("ws_addr_hsel", hsel_vec(), 32'h8);
    step();
    haddr_m   = 32'h0000_0000;
    hrdata_s1 = 32'h0000_1234;
    settle();
    check("ws_cyc1_hready", {31'h0, hready_m}, 32'h0);
    check("ws_cyc1_hsel",   hsel_vec(), 32'h1);
    step();
    settle();
    check("ws_cyc2_hready", {31'h0, hready_m}, 32'h0);
    check("ws_cyc2_hsel",   hsel_vec(), 32'h1);
    step();
    hready_s4 = 1'b1;
    settle();
    check("ws_done_hready", {31'h0, hready_m}, 32'h1);
    check("ws_done_hrdata", hrdata_m, 32'hf0f0_f0f0);
    step();
    htrans_m = IDLE;
    settle();
    check("ws_next_hrdata", hrdata_m, 32'h0000_1234);
    step();
`else
    // Region 0x3 without slave 4 behaves as the default slave
    htrans_m  = NONSEQ;
    haddr_m   = 32'h3000_0000;
    hrdata_s4 = 32'hf0f0_f0f0;
    hready_s4 = 1'b0;
    settle();
    check("r3_hsel", hsel_vec(), 32'h0);
    step();
    htrans_m = IDLE;
    settle();
    check("r3_hready", {31'h0, hready_m}, 32'h1);
    check("r3_hrdata", hrdata_m, 32'h0);
    step();
`endif

    // Unmapped address goes to the default slave
    htrans_m  = NONSEQ;
    haddr_m   = 32'h8000_0000;
    hready_s1 = 1'b0; hready_s2 = 1'b0; hready_s3 = 1'b0; hready_s4 = 1'b0;
    settle();
    check("unmap_hsel", hsel_vec(), 32'h0);
    step();
    htrans_m = IDLE;
    settle();
    check("unmap_hready", {31'h0, hready_m}, 32'h1);
    check("unmap_hrdata", hrdata_m, 32'h0);
    step();

    // Reset during a stalled data phase on slave 2 abandons it
    htrans_m  = NONSEQ;
    haddr_m   = 32'h1000_0000;
    hrdata_s2 = 32'h5555_aaaa;
    hready_s2 = 1'b0;
    settle();
    check("rst_mid_addr_hsel", hsel_vec(), 32'h2);
    step();
    settle();
    check("rst_mid_stall", {31'h0, hready_m}, 32'h0);
    hreset_n = 1'b1;
    settle();
    check("rst_mid_hready", {31'h0, hready_m}, 32'h1);
    check("rst_mid_hrdata", hrdata_m, 32'h0);
    check("rst_mid_hsel",   hsel_vec(), 32'h0);
    step();
    hreset_n = 1'b0;
    settle();
    check("post_rst_hsel", hsel_vec(), 32'h2);
    step();
    htrans_m = IDLE;
    settle();
    check("post_rst_hready", {31'h0, hready_m}, 32'h0);
    check("post_rst_hrdata", hrdata_m, 32'h5555_aaaa);
    hready_s2 = 1'b1;
    step();
    settle();
    check("post_rst_idle", {31'h0, hready_m}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
